// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_op_arbiter #(
   parameter int N         = 4,
   parameter int LAT       = 1,
   parameter int NUM_MODES = 10
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_req0_valid,
   output logic         o_req0_ready,
   input  logic [N-1:0] i_req0_in1,
   input  logic [N-1:0] i_req0_in2,
   input  logic [3:0]   i_req0_mode,
   input  logic         i_req1_valid,
   output logic         o_req1_ready,
   input  logic [N-1:0] i_req1_in1,
   input  logic [N-1:0] i_req1_in2,
   input  logic [3:0]   i_req1_mode,
   output logic         o_rsp0_valid,
   input  logic         i_rsp0_ready,
   output logic         o_rsp1_valid,
   input  logic         i_rsp1_ready,
   output logic [N-1:0] o_rsp_res,
   output logic [3:0]   o_rsp_flags,
   output logic         o_rsp_err,
   output logic [N-1:0] o_alu_in1,
   output logic [N-1:0] o_alu_in2,
   output logic [3:0]   o_alu_mode,
   input  logic [N-1:0] i_alu_res,
   input  logic [3:0]   i_alu_flags,
   output logic         o_busy
);
   localparam int CW = $clog2(LAT + 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_last;
   logic          r_owner;
   logic          w_grant;
   logic          w_xfer;
   logic          w_illegal;
   logic          w_done;
   logic [N-1:0]  w_in1;
   logic [N-1:0]  w_in2;
   logic [3:0]    w_mode;
   // grant is 1 for requester 1; ties go to whoever did not win last time
   always_comb begin
      w_grant      = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;
      w_xfer       = (r_state == IDLE) & (i_req0_valid | i_req1_valid);
      o_req0_ready = w_xfer & ~w_grant;
      o_req1_ready = w_xfer & w_grant;
      w_in1        = w_grant ? i_req1_in1 : i_req0_in1;
      w_in2        = w_grant ? i_req1_in2 : i_req0_in2;
      w_mode       = w_grant ? i_req1_mode : i_req0_mode;
      w_illegal    = int'(w_mode) >= NUM_MODES;
      w_done       = r_owner ? (o_rsp1_valid & i_rsp1_ready) : (o_rsp0_valid & i_rsp0_ready);
      o_busy       = r_state != IDLE;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_last       <= 1'b1;
         r_owner      <= 1'b0;
         o_rsp0_valid <= 1'b0;
         o_rsp1_valid <= 1'b0;
         o_rsp_res    <= '0;
         o_rsp_flags  <= '0;
         o_rsp_err    <= 1'b0;
         o_alu_in1    <= '0;
         o_alu_in2    <= '0;
         o_alu_mode   <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_xfer) begin
               r_last  <= w_grant;
               r_owner <= w_grant;
               if (w_illegal) begin
                  o_rsp_res    <= '0;
                  o_rsp_flags  <= '0;
                  o_rsp_err    <= 1'b1;
                  o_rsp0_valid <= ~w_grant;
                  o_rsp1_valid <= w_grant;
                  r_state      <= RESP;
               end else begin
                  o_alu_in1  <= w_in1;
                  o_alu_in2  <= w_in2;
                  o_alu_mode <= w_mode;
                  r_cnt      <= CW'(LAT);
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  o_rsp_res    <= i_alu_res;
                  o_rsp_flags  <= i_alu_flags;
                  o_rsp_err    <= 1'b0;
                  o_rsp0_valid <= ~r_owner;
                  o_rsp1_valid <= r_owner;
                  r_state      <= RESP;
               end
            end
            RESP: if (w_done) begin
               o_rsp0_valid <= 1'b0;
               o_rsp1_valid <= 1'b0;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
